arbiter42_enable_low_rr: RTL and testbench

- Four-requester round-robin arbiter for a shared resource.
- Grants are reported in the encoder42 output format: 2-bit code `y` plus active-low one-hot `gnt_n`.
- Requests and enable are active-low, matching the encoder family conventions.
- Sits between four active-low request sources and the shared resource.
- Holds each grant until the owner releases it or a hold timer expires.

---
 rtl/arbiter42_enable_low_rr.sv | 146 ++++++++++++++
 tb/tb_arbiter42_enable_low_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/arbiter42_enable_low_rr.sv
// Four-requester round-robin arbiter with active-low requests and enable.
// The grant is reported as a 2-bit owner code plus an active-low one-hot
// vector. A grant is held until the owner drops its request, the enable is
// deasserted, or the hold timer runs out. At least one idle cycle always
// separates two successive grants.
module arbiter42_enable_low_rr #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic [3:0] req_n,
    output logic [1:0] y,
    output logic [3:0] gnt_n,
    output logic       valid,
    output logic       expired
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Active-low one-hot image of an owner index.
    function automatic logic [3:0] grant_vector(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

    // First low request bit searching base, base+1, base+2, base+3 (mod 4).
    // Scanning from the farthest candidate back lets the nearest one win.
    function automatic logic [1:0] pick_first(input logic [1:0] base,
                                              input logic [3:0] rq_n);
        logic [1:0] idx;
        logic [1:0] result;
        result = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (!rq_n[idx]) begin
                result = idx;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    state_t            state_r;
    logic [1:0]        ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        y_r;
    logic [3:0]        gnt_n_r;
    logic              valid_r;
    logic              expired_r;

    logic              any_req_s;
    logic [1:0]        pick_s;
    logic              owner_drop_s;
    logic              timeout_s;
    logic              release_s;
    logic              timer_release_s;

    // Decode the next-owner choice and the grant termination conditions.
    always_comb begin
        any_req_s       = ~(&req_n);
        pick_s          = pick_first(ptr_r, req_n);
        owner_drop_s    = req_n[y_r];
        timeout_s       = (cnt_r == CNT_W'(MAX_HOLD - 1));
        release_s       = 1'b0;
        timer_release_s = 1'b0;
        if (e) begin
            release_s       = 1'b1;
            timer_release_s = 1'b0;
        end else if (owner_drop_s) begin
            release_s       = 1'b1;
            timer_release_s = 1'b0;
        end else if (timeout_s) begin
            release_s       = 1'b1;
            timer_release_s = 1'b1;
        end else begin
            release_s       = 1'b0;
            timer_release_s = 1'b0;
        end
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            cnt_r     <= '0;
            y_r       <= 2'd0;
            gnt_n_r   <= 4'b1111;
            valid_r   <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    expired_r <= 1'b0;
                    if (!e && any_req_s) begin
                        y_r     <= pick_s;
                        gnt_n_r <= grant_vector(pick_s);
                        valid_r <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= ST_GRANT;
                    end else begin
                        y_r     <= 2'd0;
                        gnt_n_r <= 4'b1111;
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        // The releasing owner becomes lowest priority.
                        ptr_r     <= y_r + 2'd1;
                        y_r       <= 2'd0;
                        gnt_n_r   <= 4'b1111;
                        valid_r   <= 1'b0;
                        expired_r <= timer_release_s;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                        expired_r <= 1'b0;
                        state_r   <= ST_GRANT;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    y_r       <= 2'd0;
                    gnt_n_r   <= 4'b1111;
                    valid_r   <= 1'b0;
                    expired_r <= 1'b0;
                end
            endcase
        end
    end

    assign y       = y_r;
    assign gnt_n   = gnt_n_r;
    assign valid   = valid_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_arbiter42_enable_low_rr.sv
// Bench for the round-robin arbiter: a cycle-level reference model pushes the
// expected outputs for each driven cycle into a queue; they are popped and
// compared one cycle later. Directed checks with fixed values cover the
// key scenarios.
module tb_arbiter42_enable_low_rr;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e;
    logic [3:0] req_n;
    logic [1:0] y;
    logic [3:0] gnt_n;
    logic       valid;
    logic       expired;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb_q[$];
    logic [7:0] last_obs;

    // Reference model state
    logic       m_busy;
    logic [1:0] m_owner;
    logic [1:0] m_ptr;
    int         m_cnt;
    logic       m_exp;

    arbiter42_enable_low_rr #(
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (e),
        .req_n  (req_n),
        .y      (y),
        .gnt_n  (gnt_n),
        .valid  (valid),
        .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%b required=%b", tag, obs, want);
        end
    endtask

    task automatic model_step(input logic rs, input logic en, input logic [3:0] rq);
        logic       found;
        logic [1:0] cand;
        if (!rs) begin
            m_busy = 1'b0; m_owner = 2'd0; m_ptr = 2'd0; m_cnt = 0; m_exp = 1'b0;
        end else if (!m_busy) begin
            m_exp = 1'b0;
            found = 1'b0;
            if (!en) begin
                for (int k = 0; k < 4; k++) begin
                    cand = m_ptr + 2'(k);
                    if (!found && !rq[cand]) begin
                        found   = 1'b1;
                        m_owner = cand;
                    end
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            if (en || rq[m_owner]) begin
                m_exp = 1'b0; m_ptr = m_owner + 2'd1; m_busy = 1'b0;
            end else if (m_cnt == MAX_HOLD - 1) begin
                m_exp = 1'b1; m_ptr = m_owner + 2'd1; m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] oh;
        oh = 4'b0001 << m_owner;
        if (m_busy) return {1'b1, 1'b0, m_owner, ~oh};
        else        return {1'b0, m_exp, 2'b00, 4'b1111};
    endfunction

    // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
    task automatic step(input logic rs, input logic en, input logic [3:0] rq);
        logic [7:0] want;
        rst_n = rs;
        e     = en;
        req_n = rq;
        model_step(rs, en, rq);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        last_obs = {valid, expired, y, gnt_n};
        want = sb_q.pop_front();
        chk("scoreboard", last_obs, want);
    endtask

    logic [1:0] exp_seq [5];
    int         g;
    int         run_len;
    logic       prev_valid;

    initial begin
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0; e = 1'b1; req_n = 4'b1111;

        // Reset
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);
        chk("reset_state", last_obs, 8'h0F);

        // Single request from requester 0, then release
        step(1'b1, 1'b0, 4'b1110);
        chk("t1_grant0", last_obs, 8'h8E);
        step(1'b1, 1'b0, 4'b1110);
        step(1'b1, 1'b0, 4'b1110);
        step(1'b1, 1'b0, 4'b1111);
        chk("t1_release", last_obs, 8'h0F);
        step(1'b1, 1'b0, 4'b1111);
        // ptr=1: with requesters 0 and 1 both low, 1 wins
        step(1'b1, 1'b0, 4'b1100);
        chk("t1_ptr1", last_obs, 8'h9D);
        step(1'b1, 1'b0, 4'b1111);

        // Continuous requests from all four after reset: rotation with timeouts
        step(1'b0, 1'b0, 4'b1111);
        prev_valid = 1'b0; g = 0; run_len = 0;
        for (int i = 0; i < 45; i++) begin
            step(1'b1, 1'b0, 4'b0000);
            if (valid && !prev_valid) begin
                if (g < 5) chk("rot_owner", {6'd0, y}, {6'd0, exp_seq[g]});
                g++;
                run_len = 1;
            end else if (valid) begin
                run_len++;
            end else if (prev_valid) begin
                chk("rot_len", 8'(run_len), 8'(MAX_HOLD));
                chk("rot_expired", {7'd0, expired}, 8'd1);
            end else begin
                run_len = 0;
            end
            prev_valid = valid;
        end
        chk("rot_count", 8'(g), 8'd5);
        step(1'b1, 1'b0, 4'b1111);

        // Enable high blocks grants; grant follows one cycle after enable drops
        step(1'b0, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b0111);
        step(1'b1, 1'b1, 4'b0111);
        chk("t3_disabled", last_obs, 8'h0F);
        step(1'b1, 1'b0, 4'b0111);
        chk("t3_grant3", last_obs, 8'hB7);
        step(1'b1, 1'b0, 4'b1111);

        // Enable high during a grant to requester 2
        step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1011);
        chk("t4_grant2", last_obs, 8'hAB);
        step(1'b1, 1'b0, 4'b1011);
        step(1'b1, 1'b1, 4'b1011);
        chk("t4_disable_release", last_obs, 8'h0F);
        step(1'b1, 1'b0, 4'b1010);
        chk("t4_search_3_0", last_obs, 8'h8E);
        step(1'b1, 1'b0, 4'b1111);

        // Reset mid-grant at cnt=5
        step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1110);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b1110);
        step(1'b0, 1'b0, 4'b1110);
        chk("t5_reset_mid", last_obs, 8'h0F);
        step(1'b1, 1'b0, 4'b1101);
        chk("t5_after_reset", last_obs, 8'h9D);
        step(1'b1, 1'b0, 4'b1111);

        // Requester 0 drops after 2 cycles, requester 1 then holds to timeout
        step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1100);
        chk("t6_grant0", last_obs, 8'h8E);
        step(1'b1, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b1101);
        chk("t6_idle", last_obs, 8'h0F);
        step(1'b1, 1'b0, 4'b1101);
        chk("t6_grant1", last_obs, 8'h9D);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'b1101);
        chk("t6_still_held", last_obs, 8'h9D);
        step(1'b1, 1'b0, 4'b1101);
        chk("t6_timeout", last_obs, 8'h4F);
        step(1'b1, 1'b0, 4'b1101);
        chk("t6_regrant1", last_obs, 8'h9D);
        step(1'b1, 1'b0, 4'b1111);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)));
        end

        chk("queue_drained", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
